// File: rtl/adder_operand_driver_pkg.sv
// Shared definitions for the 8-operand adder initiator: widths, limits, FSM encoding
// and an operand extraction helper.
package adder_operand_driver_pkg;

    localparam int NUM_OPS         = 8;
    localparam int OP_W            = 4;
    localparam int SUM_W           = 7;
    localparam int IDX_W           = 3;
    localparam int REQ_W           = NUM_OPS * OP_W;
    localparam int DEF_TIMEOUT_CYC = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START1 = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START2 = 3'd3,
        ST_WAIT   = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    function automatic logic [OP_W-1:0] op_at(input logic [REQ_W-1:0] ops,
                                              input logic [IDX_W-1:0] idx);
        logic [OP_W-1:0] r;
        r = {OP_W{1'b0}};
        for (int i = 0; i < NUM_OPS; i++) begin
            if (IDX_W'(i) == idx) begin
                r = ops[i*OP_W +: OP_W];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_operand_driver_operand_sum_ref.sv
// Combinational reference sum of the latched operands; 8 x 15 = 120 fits SUM_W bits.
module operand_sum_ref
    import adder_operand_driver_pkg::*;
(
    input  logic [REQ_W-1:0] operands,
    output logic [SUM_W-1:0] sum
);

    // Zero-extend each operand and accumulate
    always_comb begin
        sum = {SUM_W{1'b0}};
        for (int i = 0; i < NUM_OPS; i++) begin
            sum = sum + SUM_W'(operands[i*OP_W +: OP_W]);
        end
    end

endmodule

// File: rtl/adder_operand_driver.sv
// Initiator for the 8-operand adder: start / load 8 operands / start / await done,
// then present the captured result alongside a locally computed expected sum.
module adder_operand_driver
    import adder_operand_driver_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [REQ_W-1:0] req_operands,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [SUM_W-1:0] resp_sum,
    output logic [SUM_W-1:0] resp_expected,
    output logic             resp_mismatch,
    output logic             resp_timeout,
    output logic             add_start,
    output logic [OP_W-1:0]  add_in_data,
    output logic [IDX_W-1:0] add_in_select,
    output logic             add_in_valid,
    input  logic             add_ready,
    input  logic             add_done,
    input  logic [SUM_W-1:0] add_result
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_e             state_r;
    state_e             state_s;
    logic [REQ_W-1:0]   ops_r;
    logic [IDX_W-1:0]   idx_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [SUM_W-1:0]   sum_s;
    logic               expiry_s;
    logic               last_idx_s;
    logic               resp_valid_r;
    logic [SUM_W-1:0]   resp_sum_r;
    logic [SUM_W-1:0]   resp_expected_r;
    logic               resp_mismatch_r;
    logic               resp_timeout_r;

    operand_sum_ref u_sum_ref (
        .operands (ops_r),
        .sum      (sum_s)
    );

    assign expiry_s   = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
    assign last_idx_s = (idx_r == IDX_W'(NUM_OPS - 1));

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) state_s = ST_START1;
                else           state_s = ST_IDLE;
            end
            ST_START1: state_s = ST_LOAD;
            ST_LOAD: begin
                if (add_ready && last_idx_s) state_s = ST_START2;
                else                         state_s = ST_LOAD;
            end
            ST_START2: state_s = ST_WAIT;
            ST_WAIT: begin
                // done and expiry together resolve as done in the datapath below
                if (add_done || expiry_s) state_s = ST_RESP;
                else                      state_s = ST_WAIT;
            end
            ST_RESP: begin
                if (resp_ready) state_s = ST_IDLE;
                else            state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, operand latch, index/timeout counters and response capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            ops_r           <= {REQ_W{1'b0}};
            idx_r           <= {IDX_W{1'b0}};
            cnt_r           <= {CNT_W{1'b0}};
            resp_valid_r    <= 1'b0;
            resp_sum_r      <= {SUM_W{1'b0}};
            resp_expected_r <= {SUM_W{1'b0}};
            resp_mismatch_r <= 1'b0;
            resp_timeout_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    idx_r <= {IDX_W{1'b0}};
                    if (req_valid) ops_r <= req_operands;
                end
                ST_START1: begin
                    idx_r           <= {IDX_W{1'b0}};
                    resp_expected_r <= sum_s;
                end
                ST_LOAD: begin
                    if (add_ready) idx_r <= idx_r + IDX_W'(1'b1);
                end
                ST_START2: cnt_r <= {CNT_W{1'b0}};
                ST_WAIT: begin
                    cnt_r <= cnt_r + CNT_W'(1'b1);
                    if (add_done) begin
                        resp_valid_r    <= 1'b1;
                        resp_sum_r      <= add_result;
                        resp_mismatch_r <= (add_result != resp_expected_r);
                        resp_timeout_r  <= 1'b0;
                    end else if (expiry_s) begin
                        resp_valid_r    <= 1'b1;
                        resp_sum_r      <= {SUM_W{1'b0}};
                        resp_mismatch_r <= 1'b0;
                        resp_timeout_r  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) resp_valid_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = (state_r == ST_IDLE);
    assign add_start     = (state_r == ST_START1) || (state_r == ST_START2);
    assign add_in_valid  = (state_r == ST_LOAD) && add_ready;
    assign add_in_select = (state_r == ST_LOAD) ? idx_r : {IDX_W{1'b0}};
    assign add_in_data   = (state_r == ST_LOAD) ? op_at(ops_r, idx_r) : {OP_W{1'b0}};

    assign resp_valid    = resp_valid_r;
    assign resp_sum      = resp_sum_r;
    assign resp_expected = resp_expected_r;
    assign resp_mismatch = resp_mismatch_r;
    assign resp_timeout  = resp_timeout_r;

endmodule
